exp_scale_inv: RTL and testbench



---
 rtl/exp_scale_inv_if.sv | 21 ++
 rtl/exp_scale_inv.sv | 140 ++++++++++++++
 tb/tb_exp_scale_inv.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/exp_scale_inv_if.sv
// Handshake bundle for exp_scale_inv: scale input channel and exponent/residual result channel.
interface exp_scale_inv_if;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] scale_in;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  exp_int;
  logic [11:0] residual;
  logic        zero_in;

  modport slave (
    input  in_valid, scale_in, out_ready,
    output in_ready, out_valid, exp_int, residual, zero_in
  );

  modport master (
    output in_valid, scale_in, out_ready,
    input  in_ready, out_valid, exp_int, residual, zero_in
  );
endinterface

// File: rtl/exp_scale_inv.sv
// Inverse exponent lookup: 4-step binary search for the largest k with T[k] <= x (Q4.8 scale).
// Optional EXP_SCALE_INV_OVERLAP_EN lets a new input be accepted in the result-handshake cycle.
module exp_scale_inv (
  input  logic            clk,
  input  logic            rst,
  exp_scale_inv_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_e;

  state_e      state_q, state_d;
  logic [11:0] x_q, x_d;
  logic [3:0]  r_q, r_d;
  logic [1:0]  step_q, step_d;
  logic        out_valid_q, out_valid_d;
  logic [3:0]  exp_q, exp_d;
  logic [11:0] res_q, res_d;
  logic        zero_q, zero_d;

  logic        in_ready;
  logic        accept;
  logic [3:0]  cand;
  logic [3:0]  r_nxt;
  logic        take;

  // Entries 11..15 exceed any 12-bit x, so the search never settles above index 10.
  function automatic logic [12:0] thresh(input logic [3:0] i);
    logic [12:0] t;
    case (i)
      4'd0:    t = 13'd0;
      4'd1:    t = 13'd0;
      4'd2:    t = 13'd1;
      4'd3:    t = 13'd2;
      4'd4:    t = 13'd5;
      4'd5:    t = 13'd13;
      4'd6:    t = 13'd35;
      4'd7:    t = 13'd94;
      4'd8:    t = 13'd256;
      4'd9:    t = 13'd696;
      4'd10:   t = 13'd1892;
      default: t = 13'd4096;
    endcase
    return t;
  endfunction

`ifdef EXP_SCALE_INV_OVERLAP_EN
  assign in_ready = (state_q == IDLE) | ((state_q == DONE) & bus.out_ready);
`else
  assign in_ready = (state_q == IDLE);
`endif

  assign accept = bus.in_valid & in_ready;

  always_comb begin
    cand  = r_q | (4'd1 << step_q);
    take  = (thresh(cand) <= {1'b0, x_q});
    r_nxt = take ? cand : r_q;
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    r_d         = r_q;
    step_d      = step_q;
    out_valid_d = out_valid_q;
    exp_d       = exp_q;
    res_d       = res_q;
    zero_d      = zero_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          x_d     = bus.scale_in;
          r_d     = '0;
          step_d  = 2'd3;
          state_d = SEARCH;
        end
      end

      SEARCH: begin
        r_d    = r_nxt;
        step_d = step_q - 2'd1;
        if (step_q == 2'd0) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          exp_d       = {~r_nxt[3], r_nxt[2:0]};
          // Final threshold is always <= x < 4096, so truncating it to 12 bits is lossless.
          res_d       = x_q - 12'(thresh(r_nxt));
          zero_d      = (x_q == '0);
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
`ifdef EXP_SCALE_INV_OVERLAP_EN
          if (bus.in_valid) begin
            x_d     = bus.scale_in;
            r_d     = '0;
            step_d  = 2'd3;
            state_d = SEARCH;
          end
`endif
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      r_q         <= '0;
      step_q      <= 2'd3;
      out_valid_q <= 1'b0;
      exp_q       <= '0;
      res_q       <= '0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      r_q         <= r_d;
      step_q      <= step_d;
      out_valid_q <= out_valid_d;
      exp_q       <= exp_d;
      res_q       <= res_d;
      zero_q      <= zero_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.exp_int   = exp_q;
  assign bus.residual  = res_q;
  assign bus.zero_in   = zero_q;

endmodule

// File: tb/tb_exp_scale_inv.sv
// Scoreboard bench for exp_scale_inv: expected results queued at accept, checked at output.
module tb_exp_scale_inv;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exp_scale_inv_if bus ();

  exp_scale_inv dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [11:0] x;
    logic [3:0]  e;
    logic [11:0] r;
    logic        z;
  } exp_t;

  localparam logic [12:0] REF_TBL [16] = '{
    13'd0, 13'd0, 13'd1, 13'd2, 13'd5, 13'd13, 13'd35, 13'd94,
    13'd256, 13'd696, 13'd1892, 13'd4096, 13'd4096, 13'd4096, 13'd4096, 13'd4096
  };

`ifdef EXP_SCALE_INV_OVERLAP_EN
  localparam int SPACING = 5;
`else
  localparam int SPACING = 6;
`endif

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [11:0] x);
    exp_t m;
    int   best = 0;
    for (int i = 0; i < 16; i++)
      if (REF_TBL[i] <= {1'b0, x}) best = i;
    m.x = x;
    m.e = 4'(best - 8);
    m.r = 12'(int'(x) - int'(REF_TBL[best]));
    m.z = (x == 12'd0);
    return m;
  endfunction

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_accept(input logic [11:0] x, output bit ok, output int acc_cyc);
    int n = 0;
    bus.scale_in = x;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      step_clk();
      n++;
    end
    ok      = bus.in_ready;
    acc_cyc = 0;
    if (ok) begin
      step_clk();
      acc_cyc = cyc;
      sb.push_back(model(x));
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      step_clk();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.scale_in  = '0;
    step_clk();
    step_clk();
    rst = 1'b0;
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    tests++; if (bus.exp_int !== 4'd0) begin fails++; $display("FAIL reset_exp_int: got %h want 0", bus.exp_int); end
    tests++; if (bus.residual !== 12'd0) begin fails++; $display("FAIL reset_residual: got %h want 0", bus.residual); end
    tests++; if (bus.zero_in !== 1'b0) begin fails++; $display("FAIL reset_zero_in: got %b want 0", bus.zero_in); end
  endtask

  task automatic test_values();
    logic [11:0] xs [11];
    bit   ok;
    int   n, acc;
    exp_t e;
    xs = '{12'h100, 12'd695, 12'd696, 12'd4095, 12'd93, 12'd94, 12'd0, 12'd1, 12'h000, 12'h000, 12'h000};
    for (int i = 8; i < 11; i++) xs[i] = 12'($urandom_range(0, 4095));
    bus.out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      drive_accept(xs[i], ok, acc);
      tests++; if (!ok) begin fails++; $display("FAIL val_accept x=%0d: in_ready never rose", xs[i]); continue; end
      wait_out(n);
      tests++; if (n !== 4) begin fails++; $display("FAIL val_latency x=%0d: got %0d want 4", xs[i], n); end
      e = sb.pop_front();
      tests++; if (bus.exp_int !== e.e) begin fails++; $display("FAIL val_exp x=%0d: got %h want %h", e.x, bus.exp_int, e.e); end
      tests++; if (bus.residual !== e.r) begin fails++; $display("FAIL val_res x=%0d: got %0d want %0d", e.x, bus.residual, e.r); end
      tests++; if (bus.zero_in !== e.z) begin fails++; $display("FAIL val_zero x=%0d: got %b want %b", e.x, bus.zero_in, e.z); end
      step_clk();
      tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL val_drop x=%0d: out_valid got %b want 0", e.x, bus.out_valid); end
    end
  endtask

  task automatic test_backpressure();
    bit   ok;
    int   n, acc;
    exp_t e;
    bus.out_ready = 1'b0;
    drive_accept(12'd256, ok, acc);
    wait_out(n);
    tests++; if (n !== 4) begin fails++; $display("FAIL bp_latency: got %0d want 4", n); end
    e = sb.pop_front();
    bus.scale_in = 12'd1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL bp_hold_valid c%0d: got %b want 1", i, bus.out_valid); end
      tests++; if (bus.exp_int !== e.e || bus.residual !== e.r || bus.zero_in !== e.z) begin
        fails++; $display("FAIL bp_hold_data c%0d: got %h/%0d/%b want %h/%0d/%b", i, bus.exp_int, bus.residual, bus.zero_in, e.e, e.r, e.z);
      end
      tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready c%0d: got %b want 0", i, bus.in_ready); end
      step_clk();
    end
    bus.out_ready = 1'b1;
`ifdef EXP_SCALE_INV_OVERLAP_EN
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL bp_overlap_ready: got %b want 1", bus.in_ready); end
    step_clk();
    sb.push_back(model(12'd1));
    bus.in_valid = 1'b0;
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL bp_release_valid: got %b want 0", bus.out_valid); end
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL bp_release_ready: got %b want 0", bus.in_ready); end
`else
    step_clk();
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL bp_release_valid: got %b want 0", bus.out_valid); end
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready: got %b want 1", bus.in_ready); end
    step_clk();
    sb.push_back(model(12'd1));
    bus.in_valid = 1'b0;
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL bp_accept_ready: got %b want 0", bus.in_ready); end
`endif
    wait_out(n);
    tests++; if (n !== 4) begin fails++; $display("FAIL bp_next_latency: got %0d want 4", n); end
    e = sb.pop_front();
    tests++; if (bus.exp_int !== e.e || bus.residual !== e.r) begin
      fails++; $display("FAIL bp_next_data: got %h/%0d want %h/%0d", bus.exp_int, bus.residual, e.e, e.r);
    end
    step_clk();
  endtask

  task automatic test_reset_mid_search();
    bit   ok;
    int   n, acc;
    exp_t e;
    bus.out_ready = 1'b1;
    drive_accept(12'd4095, ok, acc);
    step_clk();
    rst = 1'b1;
    step_clk();
    rst = 1'b0;
    sb.delete();
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_valid: got %b want 0", bus.out_valid); end
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_ready: got %b want 1", bus.in_ready); end
    tests++; if (bus.exp_int !== 4'd0) begin fails++; $display("FAIL rst_mid_exp: got %h want 0", bus.exp_int); end
    tests++; if (bus.residual !== 12'd0) begin fails++; $display("FAIL rst_mid_res: got %0d want 0", bus.residual); end
    for (int i = 0; i < 6; i++) step_clk();
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_discard: got %b want 0", bus.out_valid); end
    drive_accept(12'd1892, ok, acc);
    wait_out(n);
    tests++; if (n !== 4) begin fails++; $display("FAIL rst_after_latency: got %0d want 4", n); end
    e = sb.pop_front();
    tests++; if (bus.exp_int !== e.e || bus.residual !== e.r) begin
      fails++; $display("FAIL rst_after_data: got %h/%0d want %h/%0d", bus.exp_int, bus.residual, e.e, e.r);
    end
    step_clk();
  endtask

  task automatic test_back_to_back();
    logic [11:0] xs [6];
    int acc_t [6];
    xs = '{12'd300, 12'd50, 12'd2000, 12'd0, 12'd700, 12'd3};
    bus.out_ready = 1'b1;
    fork
      begin
        bit ok;
        for (int i = 0; i < 6; i++) begin
          drive_accept(xs[i], ok, acc_t[i]);
          tests++; if (!ok) begin fails++; $display("FAIL b2b_accept %0d: in_ready never rose", i); end
        end
      end
      begin
        int   n;
        exp_t e;
        for (int j = 0; j < 6; j++) begin
          wait_out(n);
          tests++;
          if (!bus.out_valid || sb.size() == 0) begin
            fails++; $display("FAIL b2b_out %0d: out_valid=%b queued=%0d", j, bus.out_valid, sb.size());
          end else begin
            e = sb.pop_front();
            if (bus.exp_int !== e.e || bus.residual !== e.r || bus.zero_in !== e.z) begin
              fails++; $display("FAIL b2b_data x=%0d: got %h/%0d/%b want %h/%0d/%b", e.x, bus.exp_int, bus.residual, bus.zero_in, e.e, e.r, e.z);
            end
          end
          step_clk();
        end
      end
    join
    for (int i = 1; i < 6; i++) begin
      tests++; if (acc_t[i] - acc_t[i-1] !== SPACING) begin
        fails++; $display("FAIL b2b_spacing %0d: got %0d want %0d", i, acc_t[i] - acc_t[i-1], SPACING);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_values();
    test_backpressure();
    test_reset_mid_search();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
